// File: rtl/sbox_sched.sv
// sbox_sched -- arbiter and result tracker for one shared, pipelined masked S-box.
//
// Two requesters share the S-box: the state path (st_*) and the key schedule
// (ks_*). At most one request is issued per cycle, and only while the
// fresh-randomness bus is valid. A one-bit round-robin pointer settles ties.
// The granted share pair is registered onto sb_in0/sb_in1. An owner tag then
// travels down a LAT-deep pipe, so the result strobe goes to the requester
// that issued. Results have no backpressure.
//
// Parameters
//   LAT        S-box latency in cycles, counted from the sb_in update to a
//              valid sb_out (1..8)
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   st_valid/st_ready      state-path request handshake
//   st_in0/st_in1          state-path input shares
//   ks_valid/ks_ready      key-schedule request handshake
//   ks_in0/ks_in1          key-schedule input shares
//   rnd_valid              S-box randomness bus is valid this cycle
//   sb_in0/sb_in1          registered share inputs to the S-box
//   sb_out0/sb_out1        share outputs from the S-box
//   res0/res1              result shares (pass-through of sb_out)
//   st_ovalid/ks_ovalid    one-cycle result strobe to the owner
//   sb_clk_en              registered clock-gating enable for the S-box
//   busy                   at least one operation in flight
module sbox_sched #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       st_valid,
  output logic       st_ready,
  input  logic [7:0] st_in0,
  input  logic [7:0] st_in1,
  input  logic       ks_valid,
  output logic       ks_ready,
  input  logic [7:0] ks_in0,
  input  logic [7:0] ks_in1,
  input  logic       rnd_valid,
  output logic [7:0] sb_in0,
  output logic [7:0] sb_in1,
  input  logic [7:0] sb_out0,
  input  logic [7:0] sb_out1,
  output logic [7:0] res0,
  output logic [7:0] res1,
  output logic       st_ovalid,
  output logic       ks_ovalid,
  output logic       sb_clk_en,
  output logic       busy
);

  localparam int OCC_W = $clog2(LAT + 1);

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_KS = 1'b1
  } own_e;

  own_e             rr_ptr;     // requester that wins the next tie
  own_e             issue_own;
  logic             grant_st;
  logic             grant_ks;
  logic             issue;
  logic             retire;
  logic [LAT-1:0]   tag_vld_p;  // stage i holds the tag issued i+1 edges ago
  logic [LAT-1:0]   tag_own_p;  // 1 = key schedule owns that stage
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;

  // ---- issue stage: arbitration and handshake ----
  always_comb begin
    grant_st = 1'b0;
    grant_ks = 1'b0;
    if (st_valid && (!ks_valid || rr_ptr == OWN_ST)) begin
      grant_st = 1'b1;
    end else if (ks_valid) begin
      grant_ks = 1'b1;
    end
  end

  // rst_n gates ready so that no handshake is offered while reset is held.
  assign st_ready  = grant_st & rnd_valid & rst_n;
  assign ks_ready  = grant_ks & rnd_valid & rst_n;
  assign issue     = (st_valid & st_ready) | (ks_valid & ks_ready);
  assign issue_own = ks_ready ? OWN_KS : OWN_ST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= OWN_ST;
    end else if (issue) begin
      rr_ptr <= (issue_own == OWN_ST) ? OWN_KS : OWN_ST;
    end
  end

  // The share registers are only ever loaded with one requester's complete
  // share pair. They keep their value while idle, so the two shares are never
  // cleared or mixed between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_in0 <= 8'h00;
      sb_in1 <= 8'h00;
    end else if (issue) begin
      if (issue_own == OWN_KS) begin
        sb_in0 <= ks_in0;
        sb_in1 <= ks_in1;
      end else begin
        sb_in0 <= st_in0;
        sb_in1 <= st_in1;
      end
    end
  end

  // ---- tag pipe: owner tag follows the operation through the S-box ----
  // The tag pipe shifts every cycle, whether or not anything issues, so
  // in-flight work still retires while rnd_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p <= '0;
      tag_own_p <= '0;
    end else begin
      tag_vld_p[0] <= issue;
      tag_own_p[0] <= issue & (issue_own == OWN_KS);
      for (int i = 1; i < LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_own_p[i] <= tag_own_p[i-1];
      end
    end
  end

  // ---- retire stage: strobe to owner, occupancy, clock enable ----
  assign retire    = tag_vld_p[LAT-1];
  assign st_ovalid = retire & ~tag_own_p[LAT-1];
  assign ks_ovalid = retire &  tag_own_p[LAT-1];
  assign res0      = sb_out0;
  assign res1      = sb_out1;

  always_comb begin
    occ_nxt = occ;
    case ({issue, retire})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // sb_clk_en is set by the first issue edge. It stays high through the last
  // strobe cycle and drops at the edge that ends that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= '0;
      sb_clk_en <= 1'b0;
    end else begin
      occ       <= occ_nxt;
      sb_clk_en <= (occ_nxt != '0);
    end
  end

  assign busy = (occ != '0);

  ap_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(st_ready && ks_ready));

  ap_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= OCC_W'(LAT));

  ap_st_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (st_valid && !st_ready) |=> (st_valid && $stable(st_in0) && $stable(st_in1)));

  ap_ks_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ks_valid && !ks_ready) |=> (ks_valid && $stable(ks_in0) && $stable(ks_in1)));

endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 The module SHALL have parameter LAT, default 2, meaning S-box latency in cycles from an sb_in0/sb_in1 update to a valid sb_out0/sb_out1 (legal range 1..8).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports st_valid (in, 1), st_ready (out, 1), st_in0 (in, 8) and st_in1 (in, 8): state-path request and its two input shares.
REQ-005 The module SHALL have ports ks_valid (in, 1), ks_ready (out, 1), ks_in0 (in, 8) and ks_in1 (in, 8): key-schedule request and its two input shares.
REQ-006 The module SHALL have port rnd_valid, input, 1 bit: the fresh-randomness bus to the S-box is valid this cycle.
REQ-007 The module SHALL have ports sb_in0 and sb_in1, output, 8 bits each: registered share inputs to the shared masked S-box.
REQ-008 The module SHALL have ports sb_out0 and sb_out1, input, 8 bits each: share outputs from the shared masked S-box.
REQ-009 The module SHALL have ports res0 and res1, output, 8 bits each: result shares, equal combinationally to sb_out0 and sb_out1.
REQ-010 The module SHALL have ports st_ovalid and ks_ovalid, output, 1 bit each: one-cycle result strobe to the owning requester.
REQ-011 The module SHALL have port sb_clk_en, output, 1 bit: clock-gating enable for the S-box.
REQ-012 The module SHALL have port busy, output, 1 bit: at least one operation is in flight.

Function
REQ-013 The module SHALL issue at most one request per cycle, and only while rnd_valid=1.
REQ-014 The module SHALL grant with a one-bit round-robin pointer: if both requesters are valid, grant the one not granted last; if only one is valid, grant that one; the pointer updates only on an issue.
REQ-015 The module SHALL drive st_ready and ks_ready combinationally, equal to the grant qualified by rnd_valid, and SHALL never assert both in the same cycle.
REQ-016 A handshake (valid & ready) at edge E SHALL load the granted shares into sb_in0/sb_in1 at E.
REQ-017 sb_in0/sb_in1 SHALL hold their value when no issue occurs, with no zeroing and no share recombination, to avoid share interaction.
REQ-018 An issue at edge E SHALL push an owner tag into a LAT-deep tag shift register.
REQ-019 The owner's ovalid SHALL be high for exactly the one cycle following edge E+LAT-1, i.e. LAT cycles after the sb_in update.
REQ-020 Results SHALL return in issue order; back-to-back issues SHALL yield back-to-back strobes with no bubble.
REQ-021 Results SHALL have no backpressure; requesters SHALL accept a strobe when it occurs.
REQ-022 The module SHALL keep an occupancy counter of width clog2(LAT+1): +1 on issue, -1 on retire, unchanged on simultaneous issue and retire; the counter never exceeds LAT.
REQ-023 busy SHALL equal (occupancy != 0).
REQ-024 sb_clk_en SHALL be registered: high from edge E of the first issue through the cycle of the last strobe, and low the cycle after that strobe if no new issue occurs.
REQ-025 When rnd_valid=0, the module SHALL make no grant, while in-flight operations still retire and the tag pipe still shifts.
REQ-026 A requester SHALL hold valid and shares stable until ready is seen; this is checked by assertion.

Reset
REQ-027 While rst_n=0, the module SHALL drive: st_ready=ks_ready=0; st_ovalid=ks_ovalid=0; busy=0; sb_clk_en=0; sb_in0=sb_in1=0x00; tag pipe cleared; occupancy=0; round-robin pointer pointing to ST, so ST wins the first tie.
REQ-028 An rst_n assertion mid-operation SHALL discard all in-flight operations, with no strobe emitted after reset release for pre-reset issues.
REQ-029 Handshakes SHALL be possible from the first rising edge after rst_n deasserts.

Verification
REQ-030 The bench SHALL cover: LAT=2, ST only, shares 0x50/0x03 (value 0x53), rnd_valid=1 -> st_ovalid one cycle, 2 cycles after the sb_in update, with res0^res1=0xED.
REQ-031 The bench SHALL cover: ST and KS both valid every cycle for 4 cycles -> grants ST,KS,ST,KS; strobes ST,KS,ST,KS in consecutive cycles; busy high throughout.
REQ-032 The bench SHALL cover: KS valid with value 0x00 (shares 0xA5/0xA5) while rnd_valid=0 for 3 cycles, then 1 -> no ks_ready for 3 cycles, then issue, and res0^res1=0x63.
REQ-033 The bench SHALL cover: single issue followed by idle -> sb_clk_en rises at the issue edge and falls the cycle after the strobe; sb_in0/sb_in1 unchanged while idle.
REQ-034 The bench SHALL cover: rst_n pulsed low with 2 operations in flight (LAT=2) -> all outputs at reset values, no strobes afterwards, and the next tie grants ST.
REQ-035 The bench SHALL cover: LAT=1, continuous ST issue -> occupancy stays at 1 and a strobe appears every cycle.
